turn_arbiter: RTL and testbench

//  Shares the single-step board engine between the human path (button_detect
//  op codes) and the AI path (ai_top op codes). Only the side that owns the

---
 rtl/amazons_pkg.sv | 41 ++++
 rtl/turn_timer.sv | 41 ++++
 rtl/turn_arbiter.sv | 159 +++++++++++++++
 tb/tb_turn_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amazons_pkg.sv
// Shared codes for the turn arbiter: play modes, engine game-over codes,
// arbiter FSM states and the default per-turn tick budget.
package amazons_pkg;

  // Player mode as driven on p_num by Sys_ctrl.
  typedef enum logic [1:0] {
    MODE_HH     = 2'd0,  // human vs human
    MODE_HA     = 2'd1,  // human vs AI, AI plays side 1
    MODE_AA     = 2'd2,  // AI vs AI
    MODE_HA_ALT = 2'd3   // treated as MODE_HA
  } mode_e;

  // Engine game_over status.
  typedef enum logic [1:0] {
    GO_RUN       = 2'd0,
    GO_SIDE0_WON = 2'd1,
    GO_SIDE1_WON = 2'd2
  } game_over_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_WAIT_OP,
    ST_ISSUE,
    ST_PAUSED,
    ST_OVER
  } state_e;

  // 30 s at the 100 Hz tick.
  localparam int unsigned TURN_TICKS_DEF = 3000;

  // True when the given side is played by the AI in the given mode.
  function automatic logic is_ai(input logic [1:0] mode, input logic side);
    case (mode_e'(mode))
      MODE_HH: is_ai = 1'b0;
      MODE_AA: is_ai = 1'b1;
      default: is_ai = side;
    endcase
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn down-counter: load to LOAD_VAL, decrement on dec, saturate at 0.
// expire is high when the count is already 0 or reaches 0 this cycle.
module turn_timer #(
  parameter int unsigned LOAD_VAL = 3000,
  parameter int unsigned TW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [TW-1:0] count,
  output logic          expire
);

  localparam logic [TW-1:0] LOAD_W = TW'(LOAD_VAL);

  logic [TW-1:0] count_q, count_d;

  // Next count: load wins over decrement; no wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_W;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LOAD_W;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (count_q == '0) || (dec && (count_q == TW'(1)));

endmodule

// File: rtl/turn_arbiter.sv
// Turn arbiter: grants the board engine to whichever side owns the turn,
// starts the AI on its turns, flips sides on turn completion, enforces the
// per-turn time limit and handles pause and game over.
module turn_arbiter
  import amazons_pkg::*;
#(
  parameter int unsigned TURN_TICKS = TURN_TICKS_DEF,
  parameter int unsigned TW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    p_num,
  input  logic          hang,
  input  logic [1:0]    game_over,
  input  logic          tick,
  input  logic          hum_vld,
  input  logic [2:0]    hum_od,
  input  logic          ai_vld,
  input  logic [2:0]    ai_od,
  output logic          ai_rdy,
  output logic          ai_work,
  output logic          eng_vld,
  output logic [2:0]    eng_od,
  input  logic          eng_rdy,
  input  logic          turn_done,
  output logic          side,
  output logic [TW-1:0] time_left,
  output logic [1:0]    forfeit,
  output logic          hum_drop
);

  state_e     state_q, state_d;
  logic       side_q, side_d;
  logic [1:0] forfeit_q, forfeit_d;
  logic       eng_vld_q, eng_vld_d;
  logic [2:0] eng_od_q, eng_od_d;
  logic       ai_work_q, ai_work_d;

  logic owner_ai;
  logic hum_take;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_expire;
  logic tmr_run_state;

  assign owner_ai      = is_ai(p_num, side_q);
  assign tmr_run_state = (state_q == ST_TURN) || (state_q == ST_WAIT_OP) ||
                         (state_q == ST_ISSUE);
  // A turn_done accepted in WAIT_OP reloads instead of decrementing, so a
  // coincident final tick can never be seen as an expiry.
  assign tmr_dec = tick && !start && tmr_run_state &&
                   !((state_q == ST_WAIT_OP) && turn_done);

  turn_timer #(
    .LOAD_VAL (TURN_TICKS),
    .TW       (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .count  (time_left),
    .expire (tmr_expire)
  );

  // Next-state, op latching and handshake outputs.
  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    forfeit_d = forfeit_q;
    eng_vld_d = eng_vld_q;
    eng_od_d  = eng_od_q;
    ai_work_d = 1'b0;
    tmr_load  = 1'b0;
    ai_rdy    = 1'b0;
    hum_take  = 1'b0;

    if (start) begin
      state_d   = ST_TURN;
      side_d    = 1'b0;
      forfeit_d = '0;
      eng_vld_d = 1'b0;
      tmr_load  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_TURN: begin
          ai_work_d = owner_ai;
          state_d   = ST_WAIT_OP;
        end
        ST_WAIT_OP: begin
          if (game_over != GO_RUN) begin
            state_d = ST_OVER;
          end else if (tmr_expire) begin
            forfeit_d[side_q] = 1'b1;
            state_d           = ST_OVER;
          end else if (turn_done) begin
            side_d   = ~side_q;
            tmr_load = 1'b1;
            state_d  = ST_TURN;
          end else if (hang) begin
            state_d = ST_PAUSED;
          end else if (owner_ai && ai_vld) begin
            ai_rdy    = 1'b1;
            eng_od_d  = ai_od;
            eng_vld_d = 1'b1;
            state_d   = ST_ISSUE;
          end else if (!owner_ai && hum_vld) begin
            hum_take  = 1'b1;
            eng_od_d  = hum_od;
            eng_vld_d = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (eng_rdy) begin
            eng_vld_d = 1'b0;
            state_d   = ST_WAIT_OP;
          end
        end
        ST_PAUSED: begin
          if (!hang) begin
            state_d = ST_WAIT_OP;
          end
        end
        ST_OVER: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      side_q    <= 1'b0;
      forfeit_q <= '0;
      eng_vld_q <= 1'b0;
      eng_od_q  <= '0;
      ai_work_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      side_q    <= side_d;
      forfeit_q <= forfeit_d;
      eng_vld_q <= eng_vld_d;
      eng_od_q  <= eng_od_d;
      ai_work_q <= ai_work_d;
    end
  end

  assign ai_work  = ai_work_q;
  assign eng_vld  = eng_vld_q;
  assign eng_od   = eng_od_q;
  assign side     = side_q;
  assign forfeit  = forfeit_q;
  assign hum_drop = hum_vld && (state_q != ST_IDLE) && !hum_take;

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter with a short 3-tick turn budget.
module tb_turn_arbiter;
  import amazons_pkg::*;

  localparam int unsigned TT = 3;
  localparam int unsigned TW = 12;

  logic          clk = 1'b0;
  logic          rst, start, hang, tick, hum_vld, ai_vld, eng_rdy, turn_done;
  logic [1:0]    p_num, game_over;
  logic [2:0]    hum_od, ai_od;
  logic          ai_rdy, ai_work, eng_vld, side, hum_drop;
  logic [2:0]    eng_od;
  logic [TW-1:0] time_left;
  logic [1:0]    forfeit;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  turn_arbiter #(
    .TURN_TICKS (TT),
    .TW         (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p_num     (p_num),
    .hang      (hang),
    .game_over (game_over),
    .tick      (tick),
    .hum_vld   (hum_vld),
    .hum_od    (hum_od),
    .ai_vld    (ai_vld),
    .ai_od     (ai_od),
    .ai_rdy    (ai_rdy),
    .ai_work   (ai_work),
    .eng_vld   (eng_vld),
    .eng_od    (eng_od),
    .eng_rdy   (eng_rdy),
    .turn_done (turn_done),
    .side      (side),
    .time_left (time_left),
    .forfeit   (forfeit),
    .hum_drop  (hum_drop)
  );

  // The engine may only report turn completion while the arbiter waits for ops.
  always @(posedge clk) begin
    if (rst && turn_done) begin
      assert (dut.state_q == ST_WAIT_OP)
        else $error("turn_done driven outside WAIT_OP");
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hang = 1'b0; tick = 1'b0; hum_vld = 1'b0;
    ai_vld = 1'b0; eng_rdy = 1'b0; turn_done = 1'b0; p_num = 2'd1;
    game_over = 2'd0; hum_od = '0; ai_od = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_state", dut.state_q, ST_IDLE);
    check("rst_side", side, 0);
    check("rst_time", time_left, TT);
    check("rst_forfeit", forfeit, 0);
    check("rst_eng_vld", eng_vld, 0);
    check("rst_eng_od", eng_od, 0);
    check("rst_ai_work", ai_work, 0);
    check("rst_ai_rdy", ai_rdy, 0);
    rst = 1'b1;
    cyc();

    // New game in mode 1: human owns side 0
    pulse_start();
    check("start_turn", dut.state_q, ST_TURN);
    check("start_time", time_left, TT);
    cyc();
    check("start_wait", dut.state_q, ST_WAIT_OP);
    check("hum_side_no_ai_work", ai_work, 0);

    // Human op held against a stalled engine
    hum_vld = 1'b1; hum_od = 3'd5;
    #1 check("hum_take_no_drop", hum_drop, 0);
    cyc();
    hum_vld = 1'b0;
    check("issue_state", dut.state_q, ST_ISSUE);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        hum_vld = 1'b1; hum_od = 3'd3;
        #1 check("hum_drop_in_issue", hum_drop, 1);
      end
      check("hold_eng_vld", eng_vld, 1);
      check("hold_eng_od", eng_od, 5);
      cyc();
      hum_vld = 1'b0;
    end
    eng_rdy = 1'b1;
    #1 check("hs_eng_vld", eng_vld, 1);
    cyc();
    eng_rdy = 1'b0;
    check("post_hs_eng_vld", eng_vld, 0);
    check("post_hs_state", dut.state_q, ST_WAIT_OP);
    check("post_hs_eng_od", eng_od, 5);

    // Turn passes to the AI side
    turn_done = 1'b1;
    cyc();
    turn_done = 1'b0;
    check("flip_side", side, 1);
    check("flip_time", time_left, TT);
    check("ai_work_lat1", ai_work, 0);
    cyc();
    check("ai_work_lat2", ai_work, 1);
    cyc();
    check("ai_work_one_cycle", ai_work, 0);
    ai_vld = 1'b1; ai_od = 3'd2; hum_vld = 1'b1; hum_od = 3'd1;
    #1;
    check("ai_rdy_latch", ai_rdy, 1);
    check("hum_drop_ai_side", hum_drop, 1);
    cyc();
    hum_vld = 1'b0;
    #1 check("ai_rdy_in_issue", ai_rdy, 0);
    ai_vld = 1'b0;
    check("ai_eng_vld", eng_vld, 1);
    check("ai_eng_od", eng_od, 2);

    // Asynchronous reset while an op is outstanding
    rst = 1'b0;
    #1;
    check("arst_eng_vld", eng_vld, 0);
    check("arst_side", side, 0);
    check("arst_state", dut.state_q, ST_IDLE);
    rst = 1'b1;
    cyc();
    pulse_start();
    check("restart_turn", dut.state_q, ST_TURN);
    cyc();
    check("restart_wait", dut.state_q, ST_WAIT_OP);

    // AI op while the human owns the turn is held off
    ai_vld = 1'b1; ai_od = 3'd6;
    #1 check("ai_not_owner_rdy", ai_rdy, 0);
    cyc();
    ai_vld = 1'b0;
    check("ai_not_owner_state", dut.state_q, ST_WAIT_OP);
    check("ai_not_owner_vld", eng_vld, 0);

    // Pause freezes the timer
    check("pre_hang_time", time_left, TT);
    hang = 1'b1;
    cyc();
    check("hang_state", dut.state_q, ST_PAUSED);
    repeat (10) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    check("hang_time_frozen", time_left, TT);
    hum_vld = 1'b1;
    #1 check("hum_drop_paused", hum_drop, 1);
    hum_vld = 1'b0;
    hang = 1'b0;
    cyc();
    check("unhang_state", dut.state_q, ST_WAIT_OP);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("resume_dec", time_left, TT - 1);

    // turn_done beats a coincident final tick
    tick = 1'b1; cyc(); tick = 1'b0;
    check("time_at_one", time_left, 1);
    tick = 1'b1; turn_done = 1'b1;
    cyc();
    tick = 1'b0; turn_done = 1'b0;
    check("td_tick_side", side, 1);
    check("td_tick_time", time_left, TT);
    check("td_tick_forfeit", forfeit, 0);
    check("td_tick_state", dut.state_q, ST_TURN);

    // Side 0 runs out of time
    pulse_start();
    cyc();
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    check("exp_time", time_left, 0);
    check("exp_forfeit", forfeit, 1);
    check("exp_state", dut.state_q, ST_OVER);
    hum_vld = 1'b1; ai_vld = 1'b1; tick = 1'b1;
    #1;
    check("over_hum_drop", hum_drop, 1);
    check("over_ai_rdy", ai_rdy, 0);
    cyc();
    hum_vld = 1'b0; ai_vld = 1'b0; tick = 1'b0;
    check("over_eng_vld", eng_vld, 0);
    check("over_time_sat", time_left, 0);
    check("over_sticky", forfeit, 1);
    check("over_stays", dut.state_q, ST_OVER);

    // Mode 2: both sides AI, then engine reports game over
    p_num = 2'd2;
    pulse_start();
    check("mode2_forfeit_clr", forfeit, 0);
    cyc();
    check("mode2_ai_work", ai_work, 1);
    hum_vld = 1'b1;
    #1 check("mode2_hum_drop", hum_drop, 1);
    hum_vld = 1'b0;
    game_over = 2'd1;
    cyc();
    game_over = 2'd0;
    check("gameover_state", dut.state_q, ST_OVER);
    check("gameover_forfeit", forfeit, 0);

    // Mode 0: side 1 is human too
    p_num = 2'd0;
    pulse_start();
    cyc();
    turn_done = 1'b1;
    cyc();
    turn_done = 1'b0;
    cyc();
    check("mode0_side", side, 1);
    check("mode0_ai_work", ai_work, 0);
    hum_vld = 1'b1; hum_od = 3'd7;
    #1 check("mode0_hum_take", hum_drop, 0);
    cyc();
    hum_vld = 1'b0;
    check("mode0_eng_vld", eng_vld, 1);
    check("mode0_eng_od", eng_od, 7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
